inst_fetch: RTL and testbench

Instruction fetch stage of the single-issue RISC-V core. Owns the 32-word instruction memory, which the boot loader fills through a simple write port. Owns the program counter and presents one instruction per cycle to decode over a valid/ready handshake. Supports branch/jump redirect and holds off fetch while a program load is in progress.

---
 rtl/riscv_pkg.sv | 6 +
 rtl/inst_mem_array.sv | 31 +++
 rtl/inst_fetch.sv | 81 ++++++++
 tb/tb_inst_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants: data width, canonical NOP (addi x0,x0,0) and default reset vector.
package riscv_pkg;
  localparam int               XLEN             = 32;
  localparam logic [XLEN-1:0]  NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/inst_mem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
// Reset fills every word with NOP; a read of the address being written returns the old word.
module inst_mem_array
  import riscv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= W'(NOP_INST);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, redirect/load priority and a one-deep output register; 1-cycle fetch latency.
// Output holds while stalled by out_ready=0; redirect or load_busy override the stall.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 32,
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter int              AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_busy,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] inst_nxt, out_pc_nxt;
  logic            valid_nxt;
  logic [1:0]      unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // A redirect fetches its word-aligned target in the same cycle, giving a zero-bubble turn.
  assign fetch_pc = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc;

  inst_mem_array #(
    .DEPTH (DEPTH),
    .W     (XLEN),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (load_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (fetch_pc[2 +: AW]),
    .rdata (rd_data)
  );

  always_comb begin
    pc_nxt     = pc;
    valid_nxt  = out_valid;
    inst_nxt   = out_inst;
    out_pc_nxt = out_pc;
    if (load_busy) begin
      valid_nxt = 1'b0;
      pc_nxt    = RESET_PC;
    end else if (redirect_valid || !out_valid || out_ready) begin
      inst_nxt   = rd_data;
      out_pc_nxt = fetch_pc;
      valid_nxt  = 1'b1;
      pc_nxt     = fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= XLEN'(NOP_INST);
      out_pc    <= '0;
    end else begin
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_inst  <= inst_nxt;
      out_pc    <= out_pc_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized bench for inst_fetch; a spec-level model predicts every cycle's outputs.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_busy = 1'b0;
  logic        load_we = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  logic [31:0] m_pc;
  logic        e_valid;
  logic [31:0] e_inst;
  logic [31:0] e_pc;
  logic [31:0] prog [4];
  logic [31:0] old_w, new_w;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .load_busy      (load_busy),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = NOP;
    m_pc = 32'h0;
    e_valid = 1'b0;
    e_inst = NOP;
    e_pc = 32'h0;
  endtask

  // One clock edge of the specified behaviour; the fetch reads memory before this edge's write lands.
  task automatic model_edge();
    logic [31:0] t;
    if (load_busy) begin
      e_valid = 1'b0;
      m_pc = 32'h0;
    end else if (redirect_valid) begin
      t = (redirect_pc / 4) * 4;
      e_inst = m_mem[(t / 4) % 32];
      e_pc = t;
      e_valid = 1'b1;
      m_pc = t + 32'd4;
    end else if (!e_valid || out_ready) begin
      e_inst = m_mem[(m_pc / 4) % 32];
      e_pc = m_pc;
      e_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    if (load_we) m_mem[load_addr] = load_data;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, e_valid});
    chk({tag, ".pc"}, out_pc, e_pc);
    chk({tag, ".inst"}, out_inst, e_inst);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    cmp_model(tag);
  endtask

  initial begin
    prog[0] = 32'h00100093;
    prog[1] = 32'h00200113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h00000063;
    model_reset();

    // Reset state while rst is held
    @(negedge clk);
    @(negedge clk);
    cmp_model("reset");

    // Program load of all 32 words with fetch held off
    load_busy = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_we = 1'b1;
      load_addr = 5'(i);
      load_data = (i < 4) ? prog[i] : $urandom;
      step("load");
    end
    load_we = 1'b0;
    load_busy = 1'b0;
    out_ready = 1'b1;

    // Streaming from RESET_PC
    for (int i = 0; i < 3; i++) begin
      step("stream");
      chk("stream.pc_const", out_pc, 32'(i * 4));
      chk("stream.inst_const", out_inst, prog[i]);
    end

    // Stall at pc 8
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.pc_const", out_pc, 32'd8);
      chk("stall.inst_const", out_inst, 32'h002081B3);
    end
    out_ready = 1'b1;
    step("release");
    chk("release.pc_const", out_pc, 32'd12);

    // Redirect to misaligned 6 while stalled at 12
    out_ready = 1'b0;
    step("stall12");
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0006;
    step("redir6");
    chk("redir6.pc_const", out_pc, 32'd4);
    chk("redir6.inst_const", out_inst, prog[1]);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step("after_redir");
    chk("after_redir.pc_const", out_pc, 32'd8);

    // Fetch past the end of memory wraps to word 0
    redirect_valid = 1'b1;
    redirect_pc = 32'd120;
    step("wrap120");
    redirect_valid = 1'b0;
    step("wrap124");
    step("wrap128");
    chk("wrap.pc_const", out_pc, 32'd128);
    chk("wrap.inst_const", out_inst, prog[0]);

    // Same-cycle write of word 5 delivers old word; next redirect sees new one
    redirect_valid = 1'b1;
    redirect_pc = 32'd16;
    step("to16");
    redirect_valid = 1'b0;
    old_w = m_mem[5];
    new_w = ~old_w;
    load_we = 1'b1;
    load_addr = 5'd5;
    load_data = new_w;
    step("wr_same");
    chk("wr_same.old_word", out_inst, old_w);
    load_we = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'd20;
    step("wr_redir");
    chk("wr_redir.new_word", out_inst, new_w);
    redirect_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom;
      load_we = ($urandom_range(0, 5) == 0);
      load_addr = 5'($urandom);
      load_data = $urandom;
      load_busy = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    load_we = 1'b0;
    load_busy = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step("settle");

    // load_busy mid-stream, redirect in same cycle is dropped
    step("pre_busy");
    load_busy = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    step("busy");
    chk("busy.valid_const", {31'b0, out_valid}, 32'd0);
    load_busy = 1'b0;
    redirect_valid = 1'b0;
    step("busy_rel");
    chk("busy_rel.pc_const", out_pc, 32'd0);

    // Asynchronous reset mid-stream
    step("pre_rst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp_model("rst_async");
    chk("rst_async.valid_const", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step("rst_rel");
    chk("rst_rel.pc_const", out_pc, 32'd0);
    chk("rst_rel.inst_const", out_inst, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
